// File: rtl/periph_io_if.sv
// Data-memory bus between the CPU load/store path and the peripheral block.
// Master drives address/strobes/data; slave returns read data and the mux/dmem controls.
interface periph_io_if;
    logic [31:0] addr;
    logic        memread;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] periread;
    logic        memdatamuxcontrol;
    logic        dmemwrite;

    modport master (
        output addr, memread, memwrite, writedata,
        input  periread, memdatamuxcontrol, dmemwrite
    );

    modport slave (
        input  addr, memread, memwrite, writedata,
        output periread, memdatamuxcontrol, dmemwrite
    );
endinterface

// File: rtl/periph_io.sv
// Memory-mapped LED/switch/timer peripheral; reads are combinational, writes land on the next clk edge.
// No backpressure: every access completes in its own cycle, stores to the window are withheld from dmem.
module periph_io #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    periph_io_if.slave  bus,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        irq
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [15:0]   led_q, led_d;
    logic [15:0]   sw_meta_q, sw_sync_q;
    logic [31:0]   tcnt_q, tcnt_d;
    logic [31:0]   tcmp_q, tcmp_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          match_q, match_d;
    logic [PW-1:0] presc_q, presc_d;

    logic        hit, wr_en, tick, cmp_hit;
    logic [5:0]  reg_sel;
    logic [31:0] rdata;
    logic        addr_lo_unused;

    // Word-aligned decode: byte-lane bits do not select a register.
    assign hit            = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign reg_sel        = bus.addr[7:2];
    assign addr_lo_unused = ^bus.addr[1:0];
    assign wr_en          = bus.memwrite & hit;

    assign tick    = ctrl_q[0] & (presc_q == PMAX);
    assign cmp_hit = tick & (tcnt_q == tcmp_q);

    always_comb begin
        led_d   = led_q;
        tcnt_d  = tcnt_q;
        tcmp_d  = tcmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        presc_d = (!ctrl_q[0] || presc_q == PMAX) ? '0 : presc_q + PW'(1);

        if (tick) begin
            tcnt_d = (cmp_hit && ctrl_q[1]) ? 32'd0 : tcnt_q + 32'd1;
        end

        // CPU writes override the timer update; the match check above already used old TCNT.
        if (wr_en) begin
            case (reg_sel)
                6'h00: led_d  = bus.writedata[15:0];
                6'h02: tcnt_d = bus.writedata;
                6'h03: tcmp_d = bus.writedata;
                6'h04: begin
                    ctrl_d = bus.writedata[2:0];
                    if (!bus.writedata[0]) presc_d = '0;
                end
                6'h05: if (bus.writedata[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        if (cmp_hit) match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tcnt_q    <= '0;
            tcmp_q    <= 32'hFFFF_FFFF;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            presc_q   <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            tcnt_q    <= tcnt_d;
            tcmp_q    <= tcmp_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            presc_q   <= presc_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            6'h00:   rdata = {16'd0, led_q};
            6'h01:   rdata = {16'd0, sw_sync_q};
            6'h02:   rdata = tcnt_q;
            6'h03:   rdata = tcmp_q;
            6'h04:   rdata = {29'd0, ctrl_q};
            6'h05:   rdata = {31'd0, match_q};
            default: rdata = 32'd0;
        endcase
    end

    assign bus.periread          = hit ? rdata : 32'd0;
    assign bus.memdatamuxcontrol = hit & bus.memread;
    assign bus.dmemwrite         = bus.memwrite & ~hit;
    assign leds                  = led_q;
    assign irq                   = match_q & ctrl_q[2];
endmodule

// File: tb/tb_periph_io.sv
// Randomised bench for periph_io against a behavioural register/timer model.
// Directed scenarios cover reset, LED access, timer match/autoclear, W1C races, wrap and switch sync.
module tb_periph_io;
    localparam int          P    = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] switches = 16'd0;
    logic [15:0] leds;
    logic        irq;

    periph_io_if bus();

    periph_io #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .switches (switches),
        .leds     (leds),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: registers by name, plus a count of enabled cycles since the last restart.
    logic [15:0] m_led, m_sw_a, m_sw_b;
    logic [31:0] m_tcnt, m_tcmp;
    logic [2:0]  m_ctrl;
    logic        m_match;
    int          m_en_cycles;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:8] == BASE[31:8];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[7:0] & 8'hFC)
            8'h00:   return {16'd0, m_led};
            8'h04:   return {16'd0, m_sw_b};
            8'h08:   return m_tcnt;
            8'h0C:   return m_tcmp;
            8'h10:   return {29'd0, m_ctrl};
            8'h14:   return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_led = 16'd0; m_sw_a = 16'd0; m_sw_b = 16'd0;
        m_tcnt = 32'd0; m_tcmp = 32'hFFFF_FFFF;
        m_ctrl = 3'd0; m_match = 1'b0; m_en_cycles = 0;
    endtask

    task automatic m_edge();
        logic        t, mt, nm;
        logic [31:0] nt, wd;
        int          nec;
        t   = m_ctrl[0] && ((m_en_cycles % P) == P - 1);
        mt  = t && (m_tcnt == m_tcmp);
        nt  = m_tcnt;
        if (t) nt = (mt && m_ctrl[1]) ? 32'd0 : m_tcnt + 32'd1;
        nec = m_ctrl[0] ? m_en_cycles + 1 : 0;
        nm  = m_match;
        wd  = bus.writedata;
        m_sw_b = m_sw_a;
        m_sw_a = switches;
        if (bus.memwrite && m_hit(bus.addr)) begin
            case (bus.addr[7:0] & 8'hFC)
                8'h00: m_led = wd[15:0];
                8'h08: nt = wd;
                8'h0C: m_tcmp = wd;
                8'h10: begin m_ctrl = wd[2:0]; if (!wd[0]) nec = 0; end
                8'h14: if (wd[0]) nm = 1'b0;
                default: ;
            endcase
        end
        if (mt) nm = 1'b1;
        m_tcnt = nt; m_match = nm; m_en_cycles = nec;
    endtask

    task automatic check_outputs();
        logic h;
        h = m_hit(bus.addr);
        chk("periread", bus.periread, h ? m_read(bus.addr) : 32'd0);
        chk("muxctl", {31'd0, bus.memdatamuxcontrol}, {31'd0, h & bus.memread});
        chk("dmemwrite", {31'd0, bus.dmemwrite}, {31'd0, bus.memwrite & ~h});
        chk("leds", {16'd0, leds}, {16'd0, m_led});
        chk("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
    endtask

    // One bus cycle: drive just after negedge, check before posedge, advance model at posedge.
    task automatic cyc(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
        bus.addr = a; bus.memread = r; bus.memwrite = w; bus.writedata = d;
        #1 check_outputs();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        cyc(BASE | {24'd0, off}, 1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            if (m_hit(a)) a[31] = 1'b0;
            cyc(a, 1'b0, 1'b0, $urandom);
        end
    endtask

    task automatic look(input string tag, input logic [7:0] off, input logic [31:0] exp);
        bus.addr = BASE | {24'd0, off}; bus.memread = 1'b1; bus.memwrite = 1'b0;
        #1 chk(tag, bus.periread, exp);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b0;
        #1 m_reset();
        look("rst_async_tcnt", 8'h08, 32'd0);
        look("rst_async_tctrl", 8'h10, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] rand_off();
        logic [7:0] o;
        case ($urandom % 8)
            0: o = 8'h00; 1: o = 8'h04; 2: o = 8'h08; 3: o = 8'h0C;
            4: o = 8'h10; 5: o = 8'h14; 6: o = 8'h18; default: o = 8'hFC;
        endcase
        return o | 8'($urandom % 4);
    endfunction

    initial begin
        logic [31:0] a, d;
        int          r;
        bus.addr = 32'd0; bus.memread = 1'b0; bus.memwrite = 1'b0; bus.writedata = 32'd0;
        m_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state
        chk("rst_leds", {16'd0, leds}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        look("rst_tcmp", 8'h0C, 32'hFFFF_FFFF);
        idle(1);
        look("rst_tcnt", 8'h08, 32'd0);
        idle(1);

        // LED store and load
        wr(8'h00, 32'hABCD_1234);
        look("led_read", 8'h00, 32'h0000_1234);
        chk("led_mux", {31'd0, bus.memdatamuxcontrol}, 32'd1);
        chk("led_out", {16'd0, leds}, 32'h0000_1234);
        cyc(BASE, 1'b1, 1'b0, 32'd0);

        // Timer with autoclear and irq: TCNT 1,2,3 then match and back to 0
        wr(8'h0C, 32'd3);
        wr(8'h10, 32'd7);
        for (int k = 1; k <= 4; k++) begin
            idle(P);
            look("t3_tcnt", 8'h08, 32'(k % 4));
        end
        chk("t3_irq", {31'd0, irq}, 32'd1);
        idle(1);

        // W1C in the match cycle loses; a later W1C clears
        idle(4 * P - 2);
        wr(8'h14, 32'd1);
        chk("t4_set_wins", {31'd0, irq}, 32'd1);
        wr(8'h14, 32'd1);
        chk("t4_clear", {31'd0, irq}, 32'd0);

        // Wrap without match, then a store outside the window
        wr(8'h10, 32'd0);
        wr(8'h08, 32'hFFFF_FFFF);
        wr(8'h0C, 32'd5);
        wr(8'h10, 32'd1);
        idle(P - 1);
        look("t5_before", 8'h08, 32'hFFFF_FFFF);
        idle(1);
        look("t5_wrap", 8'h08, 32'd0);
        look("t5_nomatch", 8'h14, 32'd0);
        bus.addr = 32'h0000_0040; bus.memwrite = 1'b1; bus.memread = 1'b0;
        #1 chk("t5_dmemwrite", {31'd0, bus.dmemwrite}, 32'd1);
        cyc(32'h0000_0040, 1'b0, 1'b1, 32'hDEAD_BEEF);
        look("t5_led_kept", 8'h00, 32'h0000_1234);
        idle(1);

        // Reset mid-count, then prescaler restarts from 0
        wr(8'h10, 32'd0);
        wr(8'h08, 32'd2);
        wr(8'h10, 32'd1);
        idle(2);
        reset_pulse();
        wr(8'h10, 32'd1);
        idle(P - 1);
        look("t6_presc0", 8'h08, 32'd0);
        idle(1);
        look("t6_tick", 8'h08, 32'd1);
        idle(1);

        // Switch synchroniser: new value after exactly two edges
        switches = 16'hA5A5;
        idle(1);
        look("sw_1edge", 8'h04, 32'd0);
        idle(1);
        look("sw_2edge", 8'h04, 32'h0000_A5A5);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) reset_pulse();
            else if (r < 8) switches = 16'($urandom);
            if ($urandom % 4 == 0) begin
                a = $urandom;
                if (m_hit(a)) a[31] = 1'b0;
            end else begin
                a = BASE | {24'd0, rand_off()};
            end
            d = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 7));
            if ($urandom % 16 == 0) d = 32'hFFFF_FFFF;
            case ($urandom % 6)
                0, 1:    cyc(a, 1'b0, 1'b0, d);
                2, 3:    cyc(a, 1'b1, 1'b0, d);
                4:       cyc(a, 1'b0, 1'b1, d);
                default: cyc(a, 1'b1, 1'b1, d);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
